// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, write-no-allocate data cache for the MEM stage.
// Loads hit combinationally; misses fill a whole line and stores write one word through.
module data_cache_ctrl #(
    parameter int LINES          = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                         Clk,
    input  logic                         Reset_N,
    input  logic                         d_readM,
    input  logic                         d_writeM,
    input  logic [15:0]                  d_address,
    input  logic [15:0]                  d_wdata,
    output logic [15:0]                  d_rdata,
    output logic                         d_stall,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [15:0]                  mem_addr,
    output logic [15:0]                  mem_wdata,
    input  logic [16*WORDS_PER_LINE-1:0] mem_rdata,
    input  logic                         mem_ack,
    output logic [15:0]                  num_read_hit,
    output logic [15:0]                  num_read_miss
);

    localparam int LW    = 16 * WORDS_PER_LINE;
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 16 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LW-1:0]     data_q [LINES];

    logic [OFF_W-1:0]  req_off, q_off;
    logic [IDX_W-1:0]  req_idx, q_idx;
    logic [TAG_W-1:0]  req_tag, q_tag;
    logic              req_hit, q_hit;
    logic              fill_we, wr_hit_we;

    assign req_off = d_address[OFF_W-1:0];
    assign req_idx = d_address[OFF_W +: IDX_W];
    assign req_tag = d_address[OFF_W+IDX_W +: TAG_W];
    assign q_off   = addr_q[OFF_W-1:0];
    assign q_idx   = addr_q[OFF_W +: IDX_W];
    assign q_tag   = addr_q[OFF_W+IDX_W +: TAG_W];

    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign q_hit   = valid_q[q_idx] && (tag_q[q_idx] == q_tag);

    assign fill_we   = (state_q == FILL) && mem_ack;
    assign wr_hit_we = (state_q == WRITE) && mem_ack && q_hit;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (fill_we) begin
                valid_q[q_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits alone gate their use.
    always_ff @(posedge Clk) begin
        if (fill_we) begin
            tag_q[q_idx]  <= q_tag;
            data_q[q_idx] <= mem_rdata;
        end else if (wr_hit_we) begin
            data_q[q_idx][16*q_off +: 16] <= wdata_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        d_rdata    = '0;
        d_stall    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (d_writeM) begin
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                    d_stall = 1'b1;
                    state_d = WRITE;
                end else if (d_readM) begin
                    if (req_hit) begin
                        d_rdata   = data_q[req_idx][16*req_off +: 16];
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end else begin
                        addr_d     = d_address;
                        d_stall    = 1'b1;
                        miss_cnt_d = miss_cnt_q + 16'd1;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[15:OFF_W], {OFF_W{1'b0}}};
                d_stall  = !mem_ack;
                if (mem_ack) begin
                    // Forward the requested word so the pipeline can advance this cycle.
                    d_rdata = mem_rdata[16*q_off +: 16];
                    state_d = IDLE;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                d_stall   = !mem_ack;
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign num_read_hit  = hit_cnt_q;
    assign num_read_miss = miss_cnt_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench: tasks drive requests and push expected responses; a monitor
// pops and compares whenever the cache returns read data or completes a memory access.
module tb_data_cache_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        d_readM, d_writeM;
    logic [15:0] d_address, d_wdata, d_rdata;
    logic        d_stall, mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata;
    logic [15:0] num_read_hit, num_read_miss;

    int tests  = 0;
    int failed = 0;

    logic [15:0] rd_q [$];
    logic [32:0] mem_q [$];

    data_cache_ctrl #(.LINES(4), .WORDS_PER_LINE(4)) dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .d_readM(d_readM), .d_writeM(d_writeM),
        .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .num_read_hit(num_read_hit), .num_read_miss(num_read_miss)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: read completions and memory handshakes are checked against the queues.
    always @(negedge Clk) begin
        if (Reset_N === 1'b1) begin
            if (d_readM && !d_writeM && !d_stall) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 64'd1, 64'd0);
                end else begin
                    check("rd_data", d_rdata, rd_q.pop_front());
                end
            end
            if (mem_req && mem_ack) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected", 64'd1, 64'd0);
                end else begin
                    check("mem_access", {mem_we, mem_addr, mem_wdata}, mem_q.pop_front());
                end
            end
        end
    end

    task automatic read_op(input logic [15:0] addr, input logic [15:0] exp, input bit miss,
                           input int delay, input logic [63:0] line);
        rd_q.push_back(exp);
        if (miss) mem_q.push_back({1'b0, addr & 16'hFFFC, 16'h0000});
        @(posedge Clk); #1;
        d_readM = 1'b1; d_address = addr;
        @(negedge Clk);
        check("rd_stall_c0", d_stall, miss);
        check("rd_req_c0", mem_req, 0);
        if (miss) begin
            for (int c = 1; c < delay; c++) begin
                @(posedge Clk); #1;
                @(negedge Clk);
                check("rd_stall_wait", d_stall, 1);
                check("rd_req_wait", mem_req, 1);
            end
            @(posedge Clk); #1;
            mem_ack = 1'b1; mem_rdata = line;
            @(negedge Clk);
            check("rd_stall_ack", d_stall, 0);
        end
        @(posedge Clk); #1;
        d_readM = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        @(negedge Clk);
        check("rd_req_after", mem_req, 0);
    endtask

    task automatic write_op(input logic [15:0] addr, input logic [15:0] data,
                            input int delay, input bit also_read);
        mem_q.push_back({1'b1, addr, data});
        @(posedge Clk); #1;
        d_writeM = 1'b1; d_readM = also_read; d_address = addr; d_wdata = data;
        @(negedge Clk);
        check("wr_stall_c0", d_stall, 1);
        for (int c = 1; c < delay; c++) begin
            @(posedge Clk); #1;
            @(negedge Clk);
            check("wr_stall_wait", d_stall, 1);
            check("wr_we_wait", mem_we, 1);
        end
        @(posedge Clk); #1;
        mem_ack = 1'b1;
        @(negedge Clk);
        check("wr_stall_ack", d_stall, 0);
        check("wr_rdata_zero", d_rdata, 0);
        @(posedge Clk); #1;
        d_writeM = 1'b0; d_readM = 1'b0; mem_ack = 1'b0;
        @(negedge Clk);
        check("wr_req_after", mem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_N = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
        d_address = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge Clk);
        check("rst_stall", d_stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_rdata", d_rdata, 0);
        check("rst_counters", {num_read_hit, num_read_miss}, 0);
        Reset_N = 1'b1;

        // Cold miss, then hit in the same line
        read_op(16'h0012, 16'h3333, 1, 3, 64'h4444_3333_2222_1111);
        check("miss_cnt_1", num_read_miss, 1);
        read_op(16'h0011, 16'h2222, 0, 0, '0);
        check("hit_cnt_1", num_read_hit, 1);

        // Write-through hit updates the cached word
        write_op(16'h0013, 16'hBEEF, 2, 0);
        read_op(16'h0013, 16'hBEEF, 0, 0, '0);
        check("hit_cnt_2", num_read_hit, 2);

        // Conflict eviction on index 0
        read_op(16'h0052, 16'hBBBB, 1, 2, 64'hAAAA_BBBB_CCCC_DDDD);
        read_op(16'h0012, 16'h3333, 1, 1, 64'hBEEF_3333_2222_1111);
        check("miss_cnt_3", num_read_miss, 3);

        // Write miss (with read also asserted) allocates nothing
        write_op(16'h0100, 16'h1234, 3, 1);
        check("wr_no_count", {num_read_hit, num_read_miss}, {16'd2, 16'd3});
        read_op(16'h0012, 16'h3333, 0, 0, '0);
        read_op(16'h0100, 16'h1234, 1, 2, 64'h0000_0000_0000_1234);
        check("counts_pre_rst", {num_read_hit, num_read_miss}, {16'd3, 16'd4});

        // Reset in the middle of a fill
        @(posedge Clk); #1;
        d_readM = 1'b1; d_address = 16'h0011;
        @(posedge Clk); #1;
        check("fill_req_up", mem_req, 1);
        #2 Reset_N = 1'b0;
        #1 check("rst_req_drop", mem_req, 0);
        d_readM = 1'b0;
        #1 check("rst_stall_drop", d_stall, 0);
        @(negedge Clk);
        Reset_N = 1'b1;
        check("rst_counters_2", {num_read_hit, num_read_miss}, 0);
        @(posedge Clk); #1;
        mem_ack = 1'b1; mem_rdata = 64'h9999_8888_7777_6666;
        @(negedge Clk);
        check("late_ack_req", mem_req, 0);
        check("late_ack_out", {d_stall, d_rdata}, 0);
        @(posedge Clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge Clk);
        check("late_ack_idle", mem_req, 0);
        read_op(16'h0011, 16'h2222, 1, 2, 64'h4444_3333_2222_1111);
        check("counts_post_rst", {num_read_hit, num_read_miss}, {16'd0, 16'd1});

        repeat (2) @(negedge Clk);
        check("rd_q_drained", rd_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
